// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage sequencer: FSM encodings,
// parameter defaults and the saturating miss-counter helper.
package fetch_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_REFILL = 1'b1
  } fetch_state_e;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;

  localparam logic [15:0] MISS_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == MISS_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_refill_seq.sv
// Line-refill sequencer: walks one cache line over the req/ack memory port,
// generating the memory address, the line write strobe and the word index.
module fetch_refill_seq
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_i,
  input  logic [ADDR_W-1:0]             start_pc_i,
  input  logic                          mem_ack_i,
  output logic                          mem_req_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic                          refill_we_o,
  output logic [$clog2(LINE_WORDS)-1:0] refill_idx_o,
  output logic                          done_o
);

  localparam int unsigned        IDX_W    = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0]  OFF_MASK = ADDR_W'(LINE_WORDS - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(LINE_WORDS - 1);

  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ack_s;
  logic              last_s;

  // An ack only counts while a request is outstanding.
  assign ack_s  = req_q & mem_ack_i;
  assign last_s = (cnt_q == LAST_IDX);

  // Refill state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      base_q <= '0;
      req_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      base_q <= base_d;
      req_q  <= req_d;
      addr_q <= addr_d;
    end
  end

  // Next-state: launch on a miss, advance one word per ack, finish on the last word.
  always_comb begin
    cnt_d  = cnt_q;
    base_d = base_q;
    req_d  = req_q;
    addr_d = addr_q;
    if (start_i) begin
      base_d = start_pc_i & ~OFF_MASK;
      cnt_d  = '0;
      req_d  = 1'b1;
      addr_d = start_pc_i & ~OFF_MASK;
    end else if (ack_s) begin
      addr_d = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
      if (last_s) begin
        req_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign mem_req_o    = req_q;
  assign mem_addr_o   = addr_q;
  assign refill_we_o  = ack_s;
  assign refill_idx_o = cnt_q;
  assign done_o       = ack_s & last_s;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, arbitrates redirect/stall/hit/miss and
// hands misses to the line-refill sequencer.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned        ADDR_W     = DEF_ADDR_W,
  parameter int unsigned        LINE_WORDS = DEF_LINE_WORDS,
  parameter logic [ADDR_W-1:0]  RESET_PC   = ADDR_W'(DEF_RESET_PC)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          hit,
  input  logic                          stall_in,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_pc,
  output logic [ADDR_W-1:0]             pc_out,
  output logic                          fetch_valid,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_ack,
  output logic                          refill_we,
  output logic [$clog2(LINE_WORDS)-1:0] refill_idx,
  output logic [15:0]                   miss_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       miss_count_q, miss_count_d;
  logic              fetch_valid_s;
  logic              miss_s;
  logic              refill_done_s;

  // PC, FSM state and miss counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      miss_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Next-state and fetch decision; redirect outranks stall, stall outranks hit.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    miss_count_d  = miss_count_q;
    fetch_valid_s = 1'b0;
    miss_s        = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (stall_in) begin
          pc_d = pc_q;
        end else if (hit) begin
          pc_d          = pc_q + ADDR_W'(1);
          fetch_valid_s = 1'b1;
        end else begin
          miss_s       = 1'b1;
          miss_count_d = sat_inc16(miss_count_q);
          state_d      = ST_REFILL;
        end
      end
      ST_REFILL: begin
        // The refill always runs to completion; a redirect only retargets the PC.
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else begin
          pc_d = pc_q;
        end
        if (refill_done_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_REFILL;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  fetch_refill_seq #(
    .ADDR_W     (ADDR_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_refill (
    .clk          (clk),
    .reset        (reset),
    .start_i      (miss_s),
    .start_pc_i   (pc_q),
    .mem_ack_i    (mem_ack),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .refill_we_o  (refill_we),
    .refill_idx_o (refill_idx),
    .done_o       (refill_done_s)
  );

  assign pc_out      = pc_q;
  assign fetch_valid = fetch_valid_s & ~reset;
  assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (LINE_WORDS=4, RESET_PC=0x100).
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        hit;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic        fetch_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        refill_we;
  logic [1:0]  refill_idx;
  logic [15:0] miss_count;

  int vectors;
  int miscompares;

  fetch_ctrl #(
    .ADDR_W     (32),
    .LINE_WORDS (4),
    .RESET_PC   (32'h0000_0100)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .hit            (hit),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_out         (pc_out),
    .fetch_valid    (fetch_valid),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .refill_we      (refill_we),
    .refill_idx     (refill_idx),
    .miss_count     (miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [4:0]  ack_pat;
    logic [31:0] exp_addr [5];
    logic [1:0]  exp_idx  [5];

    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    hit            = 1'b0;
    stall_in       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_ack        = 1'b0;

    // Reset state
    #2;
    chk("rst_pc", pc_out, 32'h100);
    chk("rst_fv", 32'(fetch_valid), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_we", 32'(refill_we), 32'd0);
    chk("rst_mc", 32'(miss_count), 32'd0);

    // Streaming hits 0x100..0x104
    @(negedge clk);
    reset = 1'b0;
    hit   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("run_pc", pc_out, 32'h100 + 32'(i));
      chk("run_fv", 32'(fetch_valid), 32'd1);
      @(negedge clk);
    end
    #1 chk("run_pc5", pc_out, 32'h105);
    @(negedge clk);

    // Miss at 0x106
    hit = 1'b0;
    #1;
    chk("miss_pc", pc_out, 32'h106);
    chk("miss_fv", 32'(fetch_valid), 32'd0);
    chk("miss_req_pre", 32'(mem_req), 32'd0);
    @(negedge clk);
    #1;
    chk("rf_req", 32'(mem_req), 32'd1);
    chk("rf_addr0", mem_addr, 32'h104);
    chk("rf_mc", 32'(miss_count), 32'd1);

    ack_pat     = 5'b11101;
    exp_addr[0] = 32'h104; exp_addr[1] = 32'h105; exp_addr[2] = 32'h105;
    exp_addr[3] = 32'h106; exp_addr[4] = 32'h107;
    exp_idx[0]  = 2'd0; exp_idx[1] = 2'd1; exp_idx[2] = 2'd1;
    exp_idx[3]  = 2'd2; exp_idx[4] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      mem_ack = ack_pat[i];
      #1;
      chk("beat_req", 32'(mem_req), 32'd1);
      chk("beat_addr", mem_addr, exp_addr[i]);
      chk("beat_we", 32'(refill_we), 32'(ack_pat[i]));
      chk("beat_idx", 32'(refill_idx), 32'(exp_idx[i]));
      chk("beat_fv", 32'(fetch_valid), 32'd0);
      @(negedge clk);
    end

    // Back in RUN, re-lookup at 0x106 hits
    mem_ack = 1'b0;
    hit     = 1'b1;
    #1;
    chk("ret_req", 32'(mem_req), 32'd0);
    chk("ret_pc", pc_out, 32'h106);
    chk("ret_fv", 32'(fetch_valid), 32'd1);
    chk("ret_mc", 32'(miss_count), 32'd1);
    @(negedge clk);

    // Second miss at 0x107 with a redirect on beat 2
    hit = 1'b0;
    #1 chk("m2_pc", pc_out, 32'h107);
    @(negedge clk);
    #1;
    chk("m2_addr", mem_addr, 32'h104);
    chk("m2_mc", 32'(miss_count), 32'd2);
    mem_ack = 1'b1;
    #1 chk("m2_b1_idx", 32'(refill_idx), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    chk("m2_b2_idx", 32'(refill_idx), 32'd1);
    chk("m2_b2_addr", mem_addr, 32'h105);
    chk("m2_b2_fv", 32'(fetch_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("m2_b3_pc", pc_out, 32'h200);
    chk("m2_b3_req", 32'(mem_req), 32'd1);
    chk("m2_b3_idx", 32'(refill_idx), 32'd2);
    chk("m2_b3_addr", mem_addr, 32'h106);
    @(negedge clk);
    #1;
    chk("m2_b4_idx", 32'(refill_idx), 32'd3);
    chk("m2_b4_we", 32'(refill_we), 32'd1);
    @(negedge clk);
    mem_ack = 1'b0;
    hit     = 1'b1;
    #1;
    chk("m2_ret_req", 32'(mem_req), 32'd0);
    chk("m2_ret_pc", pc_out, 32'h200);
    chk("m2_ret_fv", 32'(fetch_valid), 32'd1);
    @(negedge clk);

    // Stall together with redirect: redirect wins, no fetch
    stall_in       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    #1;
    chk("sr_pc", pc_out, 32'h201);
    chk("sr_fv", 32'(fetch_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("sr_pc_new", pc_out, 32'h300);
    chk("stall_fv", 32'(fetch_valid), 32'd0);
    @(negedge clk);
    stall_in       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    #1;
    chk("stall_held", pc_out, 32'h300);
    chk("stall_mc", 32'(miss_count), 32'd2);
    chk("redir_fv", 32'(fetch_valid), 32'd0);
    @(negedge clk);

    // PC wrap from all-ones
    redirect_valid = 1'b0;
    #1;
    chk("wrap_pre", pc_out, 32'hFFFF_FFFF);
    chk("wrap_fv", 32'(fetch_valid), 32'd1);
    @(negedge clk);
    #1;
    chk("wrap_pc", pc_out, 32'h0);
    chk("wrap_req", 32'(mem_req), 32'd0);
    chk("wrap_mc", 32'(miss_count), 32'd2);

    // Miss counter preset to its ceiling, then one more miss
    force dut.miss_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.miss_count_q;
    hit = 1'b0;
    #1;
    chk("sat_pc", pc_out, 32'h1);
    chk("sat_pre", 32'(miss_count), 32'h0000_FFFF);
    @(negedge clk);
    #1;
    chk("sat_req", 32'(mem_req), 32'd1);
    chk("sat_addr", mem_addr, 32'h0);
    chk("sat_mc", 32'(miss_count), 32'h0000_FFFF);
    mem_ack = 1'b1;
    @(negedge clk);
    #1 chk("mid_addr", mem_addr, 32'h1);

    // Async reset in the middle of the refill
    reset = 1'b1;
    #1;
    chk("ar_req", 32'(mem_req), 32'd0);
    chk("ar_we", 32'(refill_we), 32'd0);
    chk("ar_fv", 32'(fetch_valid), 32'd0);
    chk("ar_pc", pc_out, 32'h100);
    chk("ar_mc", 32'(miss_count), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    mem_ack = 1'b0;
    hit     = 1'b1;
    #1;
    chk("post_pc", pc_out, 32'h100);
    chk("post_fv", 32'(fetch_valid), 32'd1);
    chk("post_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    #1 chk("post_pc1", pc_out, 32'h101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch-stage sequencer that owns the PC register and the word-address incrementer path. It drives the I-cache lookup address and advances the PC on a hit. On a miss it stalls fetch and runs a line refill over a req/ack memory port. It sits between the I-cache and the IF/ID pipeline register, and takes hazard stalls and branch redirects from later stages.

Parameters:
ADDR_W, 32, PC and memory word-address width (the PC counts words; +1 means the next instruction).
LINE_WORDS, 4, words per cache line; must be a power of two, at least 2.
RESET_PC, 0, PC value loaded at reset.

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
hit  in  1  I-cache hit for the current pc_out (combinational from cache)
stall_in  in  1  hazard stall from decode; hold the PC
redirect_valid  in  1  branch/jump taken; load redirect_pc
redirect_pc  in  ADDR_W  redirect target word address
pc_out  out  ADDR_W  current fetch address to the I-cache (registered)
fetch_valid  out  1  instruction at pc_out is valid for IF/ID this cycle
mem_req  out  1  refill request to memory (registered)
mem_addr  out  ADDR_W  refill word address (registered)
mem_ack  in  1  memory returns one word this cycle
refill_we  out  1  I-cache line write strobe (= mem_req & mem_ack)
refill_idx  out  log2(LINE_WORDS)  word index within the line being written
miss_count  out  16  saturating I-cache miss counter

Behaviour:
- Reset (async): pc=RESET_PC, state=RUN, cnt=0, miss_base=0, mem_req=0, mem_addr=0, miss_count=0. fetch_valid=0 and refill_we=0 while reset is asserted.
- FSM states: RUN, REFILL.
- RUN, evaluated in priority order:
  - redirect_valid: pc<=redirect_pc, fetch_valid=0 (squash); stall_in and hit are ignored.
  - else stall_in: pc held; fetch_valid=0.
  - else hit: pc<=pc+1 modulo 2^ADDR_W (all-ones wraps to 0); fetch_valid=1.
  - else (miss): miss_base<=pc with the low log2(LINE_WORDS) bits cleared; cnt<=0; mem_req<=1; mem_addr<=that base; miss_count+=1, saturating at 16'hFFFF; state<=REFILL; fetch_valid=0.
- fetch_valid is combinational: (state==RUN) & hit & !stall_in & !redirect_valid & !reset.
- REFILL:
  - mem_req=1. mem_addr=miss_base+cnt, held stable while mem_ack=0.
  - Each cycle with mem_ack=1: refill_we=1, refill_idx=cnt, cnt<=cnt+1, mem_addr<=miss_base+cnt+1.
  - When mem_ack=1 and cnt==LINE_WORDS-1: mem_req<=0, cnt<=0, state<=RUN.
  - The cycle after return, pc is looked up again and hits; fill latency is LINE_WORDS+1 cycles minimum.
  - fetch_valid=0 throughout.
  - stall_in is ignored (no effect on the refill).
  - redirect_valid: pc<=redirect_pc immediately, but the refill always completes; the bus is not aborted. The last redirect wins. The first lookup after return uses the new pc.
- mem_ack while mem_req=0 is ignored.
- Reset mid-refill: mem_req drops asynchronously; the partially written line is the cache's concern (the cache is also reset).

Decomposition:
- Shared package / include holds: state encodings (ST_RUN, ST_REFILL), LINE_WORDS, RESET_PC defaults.
- One natural sub-module: fetch_refill_seq (cnt, miss_base, mem_req/mem_addr/refill_we generation). The top keeps the PC register, priority mux and miss counter.

Test Plan:
- Reset with RESET_PC=0x100, hit=1 held for 5 cycles -> pc_out 0x100..0x104, fetch_valid=1 each cycle.
- Miss at pc=0x106 (LINE_WORDS=4), mem_ack pattern 1,0,1,1,1 -> mem_addr 0x104,0x105,0x105,0x106,0x107. refill_we on the acked cycles only, with idx 0,1,2,3. Return to RUN; miss_count=1; pc stays 0x106.
- redirect_valid with redirect_pc=0x200 during the second refill beat -> refill still completes all 4 words; the next RUN lookup has pc_out=0x200.
- stall_in=1 and redirect_valid=1 in the same RUN cycle -> pc loads the redirect target and fetch_valid=0. stall_in alone with hit=1 -> pc held, fetch_valid=0.
- pc=32'hFFFFFFFF with hit=1 -> next pc_out=0, no other side effects.
- Force 65536+ misses -> miss_count saturates at 16'hFFFF. Async reset mid-refill -> mem_req=0 immediately; pc=RESET_PC after release.
